// File: rtl/flash_instr_fetch_ctrl_pkg.sv
// Shared types and constants for the flash instruction fetch controller.
package flash_fetch_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    RECOVER
  } fetch_state_e;

  localparam int         FLASH_ADDR_HI_BIT = 19;
  localparam logic [1:0] INSTR_ALIGN_MASK  = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flash_instr_fetch_ctrl_if.sv
// Fetch handshake plus the shared parallel-flash bus of the two 16-bit chips.
interface flash_instr_fetch_ctrl_if #(
  parameter int FLASH_AW = 19
) ();
  import flash_fetch_pkg::*;

  logic                fetch_req;
  logic [31:0]         fetch_addr;
  logic                fetch_ready;
  logic                flush;
  logic                instr_valid;
  logic [31:0]         instr;
  logic                instr_fault;
  logic                instr_ready;
  logic                flash_ce_n;
  logic                flash_oe_n;
  logic                flash_we_n;
  logic                flash_reset_n;
  logic                flash_byte_n;
  logic [FLASH_AW-1:0] flash_a;
  logic [15:0]         flash_dq_upper;
  logic [15:0]         flash_dq_lower;

  // master: the fetch controller; slave: core IF stage plus flash chips
  modport master (
    input  fetch_req, fetch_addr, flush, instr_ready, flash_dq_upper, flash_dq_lower,
    output fetch_ready, instr_valid, instr, instr_fault,
           flash_ce_n, flash_oe_n, flash_we_n, flash_reset_n, flash_byte_n, flash_a
  );

  modport slave (
    output fetch_req, fetch_addr, flush, instr_ready, flash_dq_upper, flash_dq_lower,
    input  fetch_ready, instr_valid, instr, instr_fault,
           flash_ce_n, flash_oe_n, flash_we_n, flash_reset_n, flash_byte_n, flash_a
  );

endinterface

// File: rtl/flash_instr_fetch_ctrl_wait_timer.sv
// Loadable down-counter that saturates at zero; done while the count is zero.
module flash_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic         count_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (load_i) begin
      cnt_q <= load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/flash_instr_fetch_ctrl.sv
// Read-side initiator for the paired 16-bit instruction flash chips, returning
// 32-bit words over a valid/ready handshake with fault and flush support.
module flash_instr_fetch_ctrl
  import flash_fetch_pkg::*;
#(
  parameter int ACCESS_CYCLES     = 7,
  parameter int RECOVERY_CYCLES   = 1,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int FLASH_AW          = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  flash_instr_fetch_ctrl_if.master  bus
);

  localparam int TW = $clog2(max_int(max_int(ACCESS_CYCLES, RECOVERY_CYCLES),
                                     max_int(RESET_HOLD_CYCLES, 2))) + 1;
  localparam logic [TW-1:0] ACC_LOAD = TW'(ACCESS_CYCLES - 1);
  localparam logic [TW-1:0] REC_LOAD = TW'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);
  localparam logic [TW-1:0] RST_LOAD = TW'(RESET_HOLD_CYCLES - 1);

  fetch_state_e        state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic                fault_q, fault_d;
  logic [FLASH_AW-1:0] addr_q, addr_d;
  logic                ce_n_q, oe_n_q, reset_n_q, ready_q, valid_q;
  logic                load_d, to_recover, bad_addr;
  logic [TW-1:0]       load_val_d;
  logic                tmr_count, tmr_done;

  assign bad_addr = ((bus.fetch_addr[1:0] & INSTR_ALIGN_MASK) != 2'b00) ||
                    (bus.fetch_addr[31:FLASH_ADDR_HI_BIT+1] != '0);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    addr_d     = addr_q;
    load_d     = 1'b0;
    load_val_d = '0;
    to_recover = 1'b0;
    unique case (state_q)
      RST_HOLD: if (tmr_done) state_d = IDLE;
      IDLE: begin
        // flush wins over a same-cycle request
        if (!bus.flush && bus.fetch_req) begin
          if (bad_addr) begin
            state_d = RESP;
            instr_d = '0;
            fault_d = 1'b1;
          end else begin
            state_d = SETUP;
            fault_d = 1'b0;
            addr_d  = FLASH_AW'({bus.fetch_addr[FLASH_ADDR_HI_BIT:2], 1'b0});
          end
        end
      end
      SETUP: begin
        if (bus.flush) begin
          to_recover = 1'b1;
        end else begin
          state_d    = ACCESS;
          load_d     = 1'b1;
          load_val_d = ACC_LOAD;
        end
      end
      ACCESS: begin
        if (bus.flush) begin
          to_recover = 1'b1;
        end else if (tmr_done) begin
          state_d = RESP;
          instr_d = {bus.flash_dq_upper, bus.flash_dq_lower};
        end
      end
      RESP: begin
        if (bus.flush || bus.instr_ready) begin
          if (fault_q) state_d = IDLE;
          else         to_recover = 1'b1;
        end
      end
      RECOVER: if (tmr_done) state_d = IDLE;
      default: state_d = RST_HOLD;
    endcase

    if (to_recover) begin
      if (RECOVERY_CYCLES == 0) begin
        state_d = IDLE;
      end else begin
        state_d    = RECOVER;
        load_d     = 1'b1;
        load_val_d = REC_LOAD;
      end
    end
  end

  assign tmr_count = (state_q == RST_HOLD) || (state_q == ACCESS) || (state_q == RECOVER);

  // the timer is reloaded with the reset-hold count for as long as rst is high
  flash_wait_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .load_i     (rst | load_d),
    .count_i    (tmr_count),
    .load_val_i (rst ? RST_LOAD : load_val_d),
    .done_o     (tmr_done)
  );

  // outputs are registered decodes of the next state so the flash pins never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_HOLD;
      instr_q   <= '0;
      fault_q   <= 1'b0;
      addr_q    <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      reset_n_q <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      fault_q   <= fault_d;
      addr_q    <= addr_d;
      ce_n_q    <= !((state_d == SETUP) || (state_d == ACCESS));
      oe_n_q    <= (state_d != ACCESS);
      reset_n_q <= (state_d != RST_HOLD);
      ready_q   <= (state_d == IDLE);
      valid_q   <= (state_d == RESP);
    end
  end

  assign bus.fetch_ready   = ready_q;
  assign bus.instr_valid   = valid_q;
  assign bus.instr         = instr_q;
  assign bus.instr_fault   = fault_q;
  assign bus.flash_ce_n    = ce_n_q;
  assign bus.flash_oe_n    = oe_n_q;
  assign bus.flash_we_n    = 1'b1;
  assign bus.flash_byte_n  = 1'b1;
  assign bus.flash_reset_n = reset_n_q;
  assign bus.flash_a       = addr_q;

endmodule

// File: tb/tb_flash_instr_fetch_ctrl.sv
// Directed bench for flash_instr_fetch_ctrl with a behavioural two-chip flash model.
module tb_flash_instr_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] upper_mem [16];
  logic [15:0] lower_mem [16];

  always #5 clk = ~clk;

  flash_instr_fetch_ctrl_if #(.FLASH_AW(19)) bus ();

  flash_instr_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // flash chips drive DQ only while both CE# and OE# are low
  assign bus.flash_dq_upper = (!bus.flash_ce_n && !bus.flash_oe_n) ? upper_mem[bus.flash_a[4:1]] : 16'hDEAD;
  assign bus.flash_dq_lower = (!bus.flash_ce_n && !bus.flash_oe_n) ? lower_mem[bus.flash_a[4:1]] : 16'hBEEF;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.flash_reset_n !== 1'b0) begin n_errors++; $display("FAIL rst_reset_n: got %b want 0", bus.flash_reset_n); end
    n_checks++; if (bus.flash_ce_n !== 1'b1) begin n_errors++; $display("FAIL rst_ce_n: got %b want 1", bus.flash_ce_n); end
    n_checks++; if (bus.flash_oe_n !== 1'b1) begin n_errors++; $display("FAIL rst_oe_n: got %b want 1", bus.flash_oe_n); end
    n_checks++; if (bus.flash_we_n !== 1'b1) begin n_errors++; $display("FAIL rst_we_n: got %b want 1", bus.flash_we_n); end
    n_checks++; if (bus.flash_byte_n !== 1'b1) begin n_errors++; $display("FAIL rst_byte_n: got %b want 1", bus.flash_byte_n); end
    n_checks++; if (bus.fetch_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b want 0", bus.fetch_ready); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0) begin n_errors++; $display("FAIL rst_instr: got %h want 0", bus.instr); end
    n_checks++; if (bus.instr_fault !== 1'b0) begin n_errors++; $display("FAIL rst_fault: got %b want 0", bus.instr_fault); end
    n_checks++; if (bus.flash_a !== 19'h0) begin n_errors++; $display("FAIL rst_flash_a: got %h want 0", bus.flash_a); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.flash_reset_n !== 1'b0) begin n_errors++; $display("FAIL hold_reset_n[%0d]: got %b want 0", i, bus.flash_reset_n); end
      n_checks++; if (bus.fetch_ready !== 1'b0) begin n_errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, bus.fetch_ready); end
      n_checks++; if (bus.flash_ce_n !== 1'b1 || bus.instr_valid !== 1'b0) begin n_errors++; $display("FAIL hold_ce_valid[%0d]: got %b%b want 10", i, bus.flash_ce_n, bus.instr_valid); end
      tick();
    end
    n_checks++; if (bus.flash_reset_n !== 1'b1) begin n_errors++; $display("FAIL post_hold_reset_n: got %b want 1", bus.flash_reset_n); end
    n_checks++; if (bus.fetch_ready !== 1'b1) begin n_errors++; $display("FAIL post_hold_ready: got %b want 1", bus.fetch_ready); end
  endtask

  task automatic test_single_fetch;
    int k;
    int oe_cnt;
    bus.fetch_addr = 32'h14; bus.fetch_req = 1'b1; bus.instr_ready = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    k = 1; oe_cnt = 0;
    while (!bus.instr_valid && k < 20) begin
      if (!bus.flash_oe_n) oe_cnt++;
      if (!bus.flash_ce_n) begin
        n_checks++; if (bus.flash_a !== 19'h0000A) begin n_errors++; $display("FAIL single_flash_a[%0d]: got %h want 0000a", k, bus.flash_a); end
        n_checks++; if (bus.flash_we_n !== 1'b1 || bus.flash_byte_n !== 1'b1) begin n_errors++; $display("FAIL single_we_byte[%0d]: got %b%b want 11", k, bus.flash_we_n, bus.flash_byte_n); end
      end
      tick();
      k++;
    end
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_errors++; $display("FAIL single_timeout: got valid %b want 1", bus.instr_valid); end
    n_checks++; if (k != 9) begin n_errors++; $display("FAIL single_latency: got %0d want 9", k); end
    n_checks++; if (oe_cnt != 7) begin n_errors++; $display("FAIL single_oe_cycles: got %0d want 7", oe_cnt); end
    n_checks++; if (bus.instr !== 32'h00500513) begin n_errors++; $display("FAIL single_instr: got %h want 00500513", bus.instr); end
    n_checks++; if (bus.instr_fault !== 1'b0) begin n_errors++; $display("FAIL single_fault: got %b want 0", bus.instr_fault); end
    tick();
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.flash_ce_n !== 1'b1 || bus.fetch_ready !== 1'b0) begin n_errors++; $display("FAIL single_recover: got valid/ce_n/ready %b%b%b want 010", bus.instr_valid, bus.flash_ce_n, bus.fetch_ready); end
    tick();
    n_checks++; if (bus.fetch_ready !== 1'b1) begin n_errors++; $display("FAIL single_idle: got %b want 1", bus.fetch_ready); end
  endtask

  task automatic test_backpressure;
    int k;
    bus.fetch_addr = 32'h14; bus.fetch_req = 1'b1; bus.instr_ready = 1'b0;
    tick();
    bus.fetch_req = 1'b0;
    k = 1;
    while (!bus.instr_valid && k < 20) begin tick(); k++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00500513) begin n_errors++; $display("FAIL bp_hold[%0d]: got valid %b instr %h want 1 00500513", i, bus.instr_valid, bus.instr); end
      n_checks++; if (bus.fetch_ready !== 1'b0 || bus.flash_ce_n !== 1'b1) begin n_errors++; $display("FAIL bp_bus[%0d]: got ready %b ce_n %b want 0 1", i, bus.fetch_ready, bus.flash_ce_n); end
      if (i < 4) tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_ready !== 1'b0) begin n_errors++; $display("FAIL bp_recover: got valid %b ready %b want 0 0", bus.instr_valid, bus.fetch_ready); end
    tick();
    n_checks++; if (bus.fetch_ready !== 1'b1) begin n_errors++; $display("FAIL bp_idle: got %b want 1", bus.fetch_ready); end
  endtask

  task automatic test_fault;
    logic [31:0] fa [2];
    fa[0] = 32'h16;
    fa[1] = 32'h0010_0000;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.fetch_addr = fa[i]; bus.fetch_req = 1'b1;
      tick();
      bus.fetch_req = 1'b0;
      n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_fault !== 1'b1) begin n_errors++; $display("FAIL fault_resp[%0d]: got valid %b fault %b want 1 1", i, bus.instr_valid, bus.instr_fault); end
      n_checks++; if (bus.instr !== 32'h0) begin n_errors++; $display("FAIL fault_instr[%0d]: got %h want 0", i, bus.instr); end
      n_checks++; if (bus.flash_ce_n !== 1'b1) begin n_errors++; $display("FAIL fault_ce_n[%0d]: got %b want 1", i, bus.flash_ce_n); end
      tick();
      n_checks++; if (bus.fetch_ready !== 1'b1 || bus.instr_valid !== 1'b0 || bus.flash_ce_n !== 1'b1) begin n_errors++; $display("FAIL fault_idle[%0d]: got ready/valid/ce_n %b%b%b want 101", i, bus.fetch_ready, bus.instr_valid, bus.flash_ce_n); end
    end
  endtask

  task automatic test_flush;
    int   k;
    logic vseen;
    bus.fetch_addr = 32'h8; bus.fetch_req = 1'b1; bus.instr_ready = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.flash_oe_n !== 1'b0) begin n_errors++; $display("FAIL flush_in_access: got oe_n %b want 0", bus.flash_oe_n); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.flash_ce_n !== 1'b1 || bus.flash_oe_n !== 1'b1) begin n_errors++; $display("FAIL flush_ce_oe: got %b%b want 11", bus.flash_ce_n, bus.flash_oe_n); end
    vseen = 1'b0;
    for (int i = 0; i < 12; i++) begin vseen |= bus.instr_valid; tick(); end
    n_checks++; if (vseen !== 1'b0) begin n_errors++; $display("FAIL flush_no_valid: got %b want 0", vseen); end
    n_checks++; if (bus.fetch_ready !== 1'b1) begin n_errors++; $display("FAIL flush_idle: got %b want 1", bus.fetch_ready); end
    bus.fetch_addr = 32'hC; bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    k = 1;
    while (!bus.instr_valid && k < 20) begin tick(); k++; end
    n_checks++; if (k != 9) begin n_errors++; $display("FAIL flush_next_latency: got %0d want 9", k); end
    n_checks++; if (bus.instr !== 32'h1003_2003) begin n_errors++; $display("FAIL flush_next_instr: got %h want 10032003", bus.instr); end
    repeat (2) tick();
  endtask

  task automatic test_flush_idle_resp;
    int k;
    bus.fetch_addr = 32'h4; bus.fetch_req = 1'b1; bus.flush = 1'b1;
    tick();
    bus.fetch_req = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.fetch_ready !== 1'b1 || bus.flash_ce_n !== 1'b1) begin n_errors++; $display("FAIL flush_idle_prio: got ready %b ce_n %b want 1 1", bus.fetch_ready, bus.flash_ce_n); end
    bus.fetch_req = 1'b1; bus.instr_ready = 1'b0;
    tick();
    bus.fetch_req = 1'b0;
    k = 1;
    while (!bus.instr_valid && k < 20) begin tick(); k++; end
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1001_2001) begin n_errors++; $display("FAIL resp_flush_data: got valid %b instr %h want 1 10012001", bus.instr_valid, bus.instr); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_ready !== 1'b0) begin n_errors++; $display("FAIL resp_flush_drop: got valid %b ready %b want 0 0", bus.instr_valid, bus.fetch_ready); end
    tick();
    n_checks++; if (bus.fetch_ready !== 1'b1) begin n_errors++; $display("FAIL resp_flush_idle: got %b want 1", bus.fetch_ready); end
    bus.instr_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    int   idx, nresp, cyc, last;
    logic acc;
    logic [31:0] exp_w;
    idx = 0; nresp = 0; cyc = 0; last = 0;
    bus.fetch_addr = 32'h0; bus.fetch_req = 1'b1; bus.instr_ready = 1'b1;
    while (nresp < 4 && cyc < 100) begin
      acc = bus.fetch_req && bus.fetch_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx == 4) bus.fetch_req = 1'b0;
        else          bus.fetch_addr = 32'(idx * 4);
      end
      if (bus.instr_valid) begin
        exp_w = {16'(16'h1000 + nresp), 16'(16'h2000 + nresp)};
        n_checks++; if (bus.instr !== exp_w) begin n_errors++; $display("FAIL b2b_instr[%0d]: got %h want %h", nresp, bus.instr, exp_w); end
        if (nresp > 0) begin
          n_checks++; if (cyc - last != 11) begin n_errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 11", nresp, cyc - last); end
        end
        last = cyc;
        nresp++;
      end
    end
    n_checks++; if (nresp != 4) begin n_errors++; $display("FAIL b2b_count: got %0d want 4", nresp); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      upper_mem[i] = 16'(16'h1000 + i);
      lower_mem[i] = 16'(16'h2000 + i);
    end
    upper_mem[5] = 16'h0050;
    lower_mem[5] = 16'h0513;
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = 32'h0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_fault();
    test_flush();
    test_flush_idle_resp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/flash_instr_fetch_ctrl.md
Name: flash_instr_fetch_ctrl

Overview:
- Read-side initiator for the two 16-bit S29AL008J-style parallel flash chips that form instruction memory. One chip holds instruction bits [31:16], the other holds [15:0].
- Accepts fetch requests from the core's IF stage and drives the shared flash control and address bus with a programmable wait-state count.
- Samples both DQ buses and returns a 32-bit instruction over a valid/ready handshake, with a fault response and branch-flush support.

Parameters:
- ACCESS_CYCLES, 7, clocks with CE#/OE# both low before DQ is sampled (≥1; 7 = 70 ns at 100 MHz).
- RECOVERY_CYCLES, 1, clocks with CE#/OE# high after a response completes (0 allowed).
- RESET_HOLD_CYCLES, 4, clocks RESET# stays low after rst deasserts (≥1).
- FLASH_AW, 19, flash address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request valid
- fetch_addr  in  32  byte address of instruction
- fetch_ready  out  1  request accepted when fetch_req && fetch_ready
- flush  in  1  abort outstanding fetch; its response is discarded
- instr_valid  out  1  response valid
- instr  out  32  fetched instruction {upper DQ, lower DQ}
- instr_fault  out  1  response is a fault (misaligned or out of range)
- instr_ready  in  1  consumer accepts response
- flash_ce_n  out  1  chip enable, active-low, shared by both chips
- flash_oe_n  out  1  output enable, active-low
- flash_we_n  out  1  write enable; tied high (read-only)
- flash_reset_n  out  1  flash reset, active-low
- flash_byte_n  out  1  tied high (word mode)
- flash_a  out  FLASH_AW  flash address
- flash_dq_upper  in  16  DQ of upper chip
- flash_dq_lower  in  16  DQ of lower chip

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - State RST_HOLD.
  - fetch_ready=0, instr_valid=0, instr=0, instr_fault=0.
  - flash_ce_n=1, flash_oe_n=1, flash_reset_n=0, flash_a=0.
  - flash_we_n and flash_byte_n are 1 at all times.
- RST_HOLD: flash_reset_n stays 0 for RESET_HOLD_CYCLES clocks after rst drops, then goes to 1 → IDLE.
- IDLE: fetch_ready=1. On accept:
  - If fetch_addr[1:0]!=0 or fetch_addr[31:20]!=0 → RESP with instr_fault=1 and instr=0. No flash activity occurs.
  - Otherwise register flash_a = {fetch_addr[19:2], 1'b0} → SETUP. Flash word index is A[18:1] and A[0] is always 0.
- SETUP (1 clk): ce_n=0, oe_n=1, address stable → ACCESS.
- ACCESS (ACCESS_CYCLES clks): ce_n=0, oe_n=0.
  - At the edge ending the last ACCESS cycle, capture instr = {flash_dq_upper, flash_dq_lower} → RESP.
- RESP: instr_valid=1, ce_n=oe_n=1.
  - instr and instr_fault are held stable until instr_ready.
  - On handshake → RECOVER, or → IDLE if RECOVERY_CYCLES==0 or the response was a fault.
- RECOVER (RECOVERY_CYCLES clks): ce_n=oe_n=1 → IDLE.
- fetch_ready is 1 only in IDLE.
- Latency: a request accepted in cycle T gives instr_valid in cycle T+2+ACCESS_CYCLES (9 by default). A fault gives instr_valid in T+1.
- Back-to-back throughput with instr_ready held high is one fetch per 3+ACCESS_CYCLES+RECOVERY_CYCLES clks.
- flush:
  - In SETUP or ACCESS: drop ce_n/oe_n the next cycle, discard data, → RECOVER. instr_valid never asserts for that fetch.
  - In RESP: drop instr_valid the next cycle, → RECOVER (IDLE for a fault).
  - In IDLE: a flush takes priority over a simultaneous fetch_req, which is not accepted.
  - In RST_HOLD or RECOVER: flush has no effect.
- rst asserted mid-access: the next cycle returns to reset values. flash_reset_n goes to 0 and any in-flight data is lost.
- The ACCESS and RECOVER counters are sized to ceil(log2(max(param,2)))+1 bits and never wrap.

Decomposition:
- Package flash_fetch_pkg:
  - State enum {RST_HOLD, IDLE, SETUP, ACCESS, RESP, RECOVER}.
  - FLASH_ADDR_HI_BIT=19 and INSTR_ALIGN_MASK=2'b11.
- Sub-module flash_wait_timer: a loadable down-counter with load, count and done outputs. It is shared for the RST_HOLD, ACCESS and RECOVER durations.

Test Plan:
- Reset: hold rst 3 clks then release → flash_reset_n=0 for exactly 4 clks, fetch_ready rises on the 5th. ce_n, oe_n, we_n, byte_n and instr_valid have the values listed under Behaviour throughout.
- Single fetch: both flash models preloaded, upper[5]=16'h0050 and lower[5]=16'h0513; request addr 32'h14 with instr_ready=1.
  - flash_a=19'h0000A.
  - oe_n low exactly 7 clks.
  - instr_valid=1 with instr=32'h00500513, 9 clks after accept.
- Back-pressure: hold instr_ready=0 for 5 clks after valid → instr stays constant, fetch_ready=0, ce_n=1. Release → one RECOVER cycle, then IDLE.
- Faults: addr 32'h16 → instr_fault=1, instr=0 the next clk, ce_n never falls. addr 32'h0010_0000 gives the same result.
- Flush: pulse flush in the 3rd ACCESS cycle of a fetch to 32'h8 → no instr_valid. ce_n high the next clk. The next request (32'hC) returns upper[3]/lower[3] correctly.
- Streaming: 4 back-to-back requests at 32'h0, 32'h4, 32'h8, 32'hC with instr_ready=1 → 4 responses in order, spaced 11 clks apart.
